// File: rtl/cory_dupn.sv
// cory_dupn: M-way eager broadcast/multicast fork on a valid/ready stream.
// Each input beat is copied to every channel selected by its mask. Channels
// take their copy independently, and the beat retires once every selected
// channel holds one. With Q>0, each channel gets its own Q-deep FIFO so slow
// consumers do not throttle fast ones until their queue fills.
module cory_dupn #(
  parameter int N = 16,
  parameter int M = 4,
  parameter int Q = 0
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           i_a_v,
  input  logic [N-1:0]   i_a_d,
  input  logic [M-1:0]   i_a_m,
  output logic           o_a_r,
  output logic [M-1:0]   o_z_v,
  output logic [M*N-1:0] o_z_d,
  input  logic [M-1:0]   i_z_r,
  output logic [M-1:0]   o_pend
);

  // done[k]: channel k already holds a copy of the beat being presented.
  logic [M-1:0] done;
  logic [M-1:0] req;
  logic [M-1:0] in_r;
  logic [M-1:0] take;
  logic         accept;

  // A channel still owes a copy when it is selected and not yet served.
  assign req    = {M{i_a_v}} & i_a_m & ~done;
  assign take   = req & in_r;

  // The beat can retire once every selected channel is served or can take it
  // now. Deliberately independent of i_a_v, so an empty mask is always ready.
  assign o_a_r  = &(~i_a_m | done | in_r);
  assign accept = i_a_v & o_a_r;
  assign o_pend = done;

  // Remember which channels got their copy; forget all of it when the beat retires
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done <= '0;
    end else if (accept) begin
      done <= '0;
    end else begin
      done <= done | take;
    end
  end

  generate
    if (Q == 0) begin : g_direct
      // Unbuffered: each channel sees the producer directly, zero latency.
      assign in_r  = i_z_r;
      assign o_z_v = req;
      assign o_z_d = {M{i_a_d}};
    end else begin : g_fifo
      localparam int PW = (Q > 1) ? $clog2(Q) : 1;
      localparam int CW = $clog2(Q + 1);

      for (genvar k = 0; k < M; k++) begin : g_ch
        logic [N-1:0]  mem [Q];
        logic [PW-1:0] wp;
        logic [PW-1:0] rp;
        logic [CW-1:0] cnt;
        logic          full;
        logic          empty;
        logic          push;
        logic          pop;

        // full comes only from registered occupancy: a pop in the same cycle
        // never opens room for a push, keeping ready free of comb paths.
        assign full  = (cnt == CW'(Q));
        assign empty = (cnt == '0);
        assign push  = req[k] & ~full;
        assign pop   = ~empty & i_z_r[k];

        assign in_r[k]          = ~full;
        assign o_z_v[k]         = ~empty;
        // Gate the head with empty so stale storage never shows on the bus.
        assign o_z_d[k*N +: N]  = empty ? '0 : mem[rp];

        // Pointer and occupancy bookkeeping; pointers wrap at Q-1 for any Q
        always_ff @(posedge clk or negedge reset_n) begin
          if (!reset_n) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
          end else begin
            if (push) begin
              wp <= (wp == PW'(Q - 1)) ? '0 : wp + PW'(1);
            end
            if (pop) begin
              rp <= (rp == PW'(Q - 1)) ? '0 : rp + PW'(1);
            end
            cnt <= cnt + CW'(push) - CW'(pop);
          end
        end

        // Storage write; contents need no reset because empty masks the head
        always_ff @(posedge clk) begin
          if (push) begin
            mem[wp] <= i_a_d;
          end
        end
      end
    end
  endgenerate

endmodule
